// File: rtl/div_iter_pkg.sv
`default_nettype none
// div_iter_pkg: shared constants and state encoding for the iterative divider. Rev 1.0
package div_iter_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = 5;

  localparam logic [DIV_CNT_W-1:0] DIV_CNT_LAST     = '1;
  localparam logic [DIV_WIDTH-1:0] DIV_OVF_DIVIDEND = 32'h8000_0000;
  localparam logic [DIV_WIDTH-1:0] DIV_OVF_DIVISOR  = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_SIGN = 2'd2
  } div_state_e;

endpackage
`default_nettype wire

// File: rtl/div_sub_stage.sv
`default_nettype none
// div_sub_stage: N-bit minuend - subtrahend as inverted-add with carry-in 1 on 4-bit lookahead blocks. Rev 1.0
module div_sub_stage #(
  parameter int N = 33
) (
  input  logic [N-1:0] minuend,
  input  logic [N-1:0] subtrahend,
  output logic [N-2:0] diff,
  output logic         borrow
);

  localparam int BLK = 4;
  localparam int NB  = (N + BLK - 1) / BLK;

  logic [N-1:0]  g;
  logic [N-1:0]  p;
  logic [N-1:0]  s;
  logic [NB-1:0] c;
  logic [NB-2:0] bg;
  logic [NB-2:0] bp;

  assign g = minuend & ~subtrahend;
  assign p = minuend ^ ~subtrahend;

  // Block carries resolved from group generate/propagate, carry-in 1 completes the negation.
  always_comb begin
    c    = '0;
    c[0] = 1'b1;
    for (int k = 0; k < NB - 1; k++) begin
      c[k+1] = bg[k] | (bp[k] & c[k]);
    end
  end

  for (genvar k = 0; k < NB; k++) begin : g_blk
    localparam int LO = k * BLK;
    localparam int BW = (LO + BLK > N) ? (N - LO) : BLK;

    logic [BW-1:0] sb;

    always_comb begin
      logic cr;
      cr = c[k];
      sb = '0;
      for (int i = 0; i < BW; i++) begin
        sb[i] = p[LO+i] ^ cr;
        cr    = g[LO+i] | (p[LO+i] & cr);
      end
    end

    assign s[LO+BW-1:LO] = sb;

    if (k < NB - 1) begin : g_prop
      logic gg;
      logic pp;
      always_comb begin
        gg = 1'b0;
        pp = 1'b1;
        for (int i = 0; i < BW; i++) begin
          gg = g[LO+i] | (p[LO+i] & gg);
          pp = pp & p[LO+i];
        end
      end
      assign bg[k] = gg;
      assign bp[k] = pp;
    end
  end

  // Both operands are below 2^(N-1), so the top bit of the difference is the borrow.
  assign diff   = s[N-2:0];
  assign borrow = s[N-1];

endmodule
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// div_iter: 32-bit signed restoring divider, one quotient bit per cycle.
// Remainder output is built only when DIV_REMAINDER_EN is defined. Rev 1.0
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  div_state_e state;
  div_state_e next_state;

  logic [WIDTH-1:0]     q;
  logic [WIDTH-1:0]     r;
  logic [WIDTH-1:0]     dmag;
  logic [DIV_CNT_W-1:0] cnt;
  logic                 qsign;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   minuend;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             is_exc;

  // 0x80000000 negates to itself and is then read as an unsigned magnitude.
  assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  assign is_exc = (data_operandB == '0) ||
                  ((data_operandA == DIV_OVF_DIVIDEND) && (data_operandB == DIV_OVF_DIVISOR));

  assign minuend = {r, q[WIDTH-1]};

  div_sub_stage #(
    .N(WIDTH + 1)
  ) u_sub (
    .minuend   (minuend),
    .subtrahend({1'b0, dmag}),
    .diff      (diff),
    .borrow    (borrow)
  );

  assign busy = (state != DIV_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= DIV_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      DIV_IDLE: if (ctrl_div && !is_exc)  next_state = DIV_RUN;
      DIV_RUN:  if (cnt == DIV_CNT_LAST) next_state = DIV_SIGN;
      DIV_SIGN: next_state = DIV_IDLE;
      default:  next_state = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q              <= '0;
      r              <= '0;
      dmag           <= '0;
      cnt            <= '0;
      qsign          <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (ctrl_div) begin
            if (is_exc) begin
              data_result    <= '0;
              data_exception <= 1'b1;
              data_resultRDY <= 1'b1;
            end else begin
              q     <= a_mag;
              r     <= '0;
              dmag  <= b_mag;
              cnt   <= '0;
              qsign <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            end
          end
        end
        DIV_RUN: begin
          q   <= {q[WIDTH-2:0], ~borrow};
          r   <= borrow ? minuend[WIDTH-1:0] : diff;
          cnt <= cnt + 1'b1;
        end
        DIV_SIGN: begin
          data_result    <= qsign ? -q : q;
          data_exception <= 1'b0;
          data_resultRDY <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_REMAINDER_EN
  logic rsign;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsign          <= 1'b0;
      data_remainder <= '0;
    end else if (state == DIV_IDLE && ctrl_div) begin
      if (is_exc) data_remainder <= '0;
      else        rsign          <= data_operandA[WIDTH-1];
    end else if (state == DIV_SIGN) begin
      data_remainder <= rsign ? -r : r;
    end
  end
`else
  assign data_remainder = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_div_iter.sv
`default_nettype none
// tb_div_iter: directed vector table plus multi-cycle corner sequences for div_iter.
module tb_div_iter;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ctrl_div = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic [31:0] data_result;
  logic [31:0] data_remainder;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        exc;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  div_iter dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .ctrl_div      (ctrl_div),
    .data_operandA (opa),
    .data_operandB (opb),
    .data_result   (data_result),
    .data_remainder(data_remainder),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rem_exp(input logic [31:0] v);
`ifdef DIV_REMAINDER_EN
    return v;
`else
    return 32'h0;
`endif
  endfunction

  // Leaves the bench at the falling edge right after the start edge.
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    opa = a;
    opb = b;
    ctrl_div = 1'b1;
    @(negedge clock);
    ctrl_div = 1'b0;
  endtask

  // lat counts rising edges after the start edge.
  task automatic await_rdy(inout int lat);
    while (!data_resultRDY && lat < 40) begin
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic check_done(input string tag, input vec_t v, input int lat);
    chk({tag, "_latency"}, lat, v.lat);
    chk({tag, "_result"}, data_result, v.q);
    chk({tag, "_remainder"}, data_remainder, rem_exp(v.r));
    chk({tag, "_exception"}, 32'(data_exception), 32'(v.exc));
    chk({tag, "_busy_end"}, 32'(busy), 32'h0);
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    int lat;
    launch(v.a, v.b);
    chk({tag, "_busy_start"}, 32'(busy), 32'(!v.exc));
    lat = 0;
    await_rdy(lat);
    check_done(tag, v, lat);
    @(negedge clock);
    chk({tag, "_rdy_drop"}, 32'(data_resultRDY), 32'h0);
  endtask

  initial begin
    int   lat;
    int   rdy_seen;
    vec_t v;

    vecs[0]  = '{32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 33};
    vecs[1]  = '{32'hFFFFFF9C,  32'd7,         32'hFFFFFFF2,  32'hFFFFFFFE,  1'b0, 33};
    vecs[2]  = '{32'd100,       32'hFFFFFFF9,  32'hFFFFFFF2,  32'd2,         1'b0, 33};
    vecs[3]  = '{32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  1'b0, 33};
    vecs[4]  = '{32'd5,         32'd0,         32'd0,         32'd0,         1'b1, 0};
    vecs[5]  = '{32'h80000000,  32'hFFFFFFFF,  32'd0,         32'd0,         1'b1, 0};
    vecs[6]  = '{32'h80000000,  32'd1,         32'h80000000,  32'd0,         1'b0, 33};
    vecs[7]  = '{32'h7FFFFFFF,  32'h80000000,  32'd0,         32'h7FFFFFFF,  1'b0, 33};
    vecs[8]  = '{32'h80000000,  32'h80000000,  32'd1,         32'd0,         1'b0, 33};
    vecs[9]  = '{32'd0,         32'd5,         32'd0,         32'd0,         1'b0, 33};
    vecs[10] = '{32'd7,         32'd7,         32'd1,         32'd0,         1'b0, 33};
    vecs[11] = '{32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 33};
    vecs[12] = '{32'h80000000,  32'd3,         32'hD5555556,  32'hFFFFFFFE,  1'b0, 33};
    vecs[13] = '{32'hFFFFFFFF,  32'h80000000,  32'd0,         32'hFFFFFFFF,  1'b0, 33};

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset_result", data_result, 32'h0);
    chk("reset_remainder", data_remainder, 32'h0);
    chk("reset_exception", 32'(data_exception), 32'h0);
    chk("reset_rdy", 32'(data_resultRDY), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      run_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Start while busy is ignored; result is that of 9/2.
    v = '{32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 33};
    launch(v.a, v.b);
    lat = 0;
    repeat (9) begin
      @(negedge clock);
      lat++;
    end
    opa = 32'd1;
    opb = 32'd1;
    ctrl_div = 1'b1;
    @(negedge clock);
    lat++;
    ctrl_div = 1'b0;
    await_rdy(lat);
    check_done("ignore", v, lat);

    // Back-to-back start on the RDY cycle.
    opa = 32'd100;
    opb = 32'd7;
    ctrl_div = 1'b1;
    @(negedge clock);
    ctrl_div = 1'b0;
    chk("b2b_busy_start", 32'(busy), 32'h1);
    chk("b2b_rdy_drop", 32'(data_resultRDY), 32'h0);
    chk("b2b_result_hold", data_result, 32'd4);
    lat = 0;
    await_rdy(lat);
    check_done("b2b", vecs[0], lat);

    // Asynchronous reset mid-run aborts without RDY.
    launch(32'd1000, 32'd3);
    repeat (14) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_result", data_result, 32'h0);
    chk("abort_remainder", data_remainder, 32'h0);
    chk("abort_exception", 32'(data_exception), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_rdy", 32'(data_resultRDY), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    rdy_seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) rdy_seen++;
    end
    chk("abort_no_rdy", rdy_seen, 0);
    run_vec("after_abort", vecs[0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
